// File: rtl/hdmi_video_timing_if.sv
// Video timing bundle: SDRAM read-FIFO request/data plus the sync/DE/RGB video bus.
interface hdmi_video_timing_if;
  logic [15:0] rd_data;
  logic        pattern_en;
  logic        rd_en;
  logic        video_hs;
  logic        video_vs;
  logic        video_de;
  logic [23:0] video_rgb;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic        frame_start;

  modport master (
    input  rd_data, pattern_en,
    output rd_en, video_hs, video_vs, video_de, video_rgb,
           pixel_xpos, pixel_ypos, h_disp, v_disp, frame_start
  );

  modport slave (
    output rd_data, pattern_en,
    input  rd_en, video_hs, video_vs, video_de, video_rgb,
           pixel_xpos, pixel_ypos, h_disp, v_disp, frame_start
  );
endinterface

// File: rtl/hdmi_video_timing.sv
// HDMI raster timing generator with a centred camera window fed from an SDRAM FIFO.
// Optional colour-bar generator inside the window: define TEST_PATTERN_EN.
module hdmi_video_timing #(
  parameter int H_SYNC  = 40,
  parameter int H_BACK  = 220,
  parameter int H_DISP  = 1280,
  parameter int H_FRONT = 110,
  parameter int V_SYNC  = 5,
  parameter int V_BACK  = 20,
  parameter int V_DISP  = 720,
  parameter int V_FRONT = 5,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  hdmi_video_timing_if.master vid
);
  localparam int CW = 11;
  localparam logic [CW-1:0] H_LAST  = CW'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] H_DISP_C = CW'(H_DISP);
  localparam logic [CW-1:0] V_DISP_C = CW'(V_DISP);
  localparam logic [CW-1:0] X_OFF_C  = CW'((H_DISP - IMG_W) / 2);
  localparam logic [CW-1:0] Y_OFF_C  = CW'((V_DISP - IMG_H) / 2);
  localparam logic [CW-1:0] IMG_W_C  = CW'(IMG_W);
  localparam logic [CW-1:0] IMG_H_C  = CW'(IMG_H);

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] hr, vr, xr, yr;
  logic          hs0, vs0, de0, win0, win_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Offsets are taken modulo 2^CW so a single unsigned compare covers both range bounds.
  always_comb begin
    hr   = h_cnt - H_ACT_C;
    vr   = v_cnt - V_ACT_C;
    xr   = hr - X_OFF_C;
    yr   = vr - Y_OFF_C;
    hs0  = h_cnt < H_SYNC_C;
    vs0  = v_cnt < V_SYNC_C;
    de0  = (hr < H_DISP_C) && (vr < V_DISP_C);
    win0 = de0 && (xr < IMG_W_C) && (yr < IMG_H_C);
  end

  assign vid.rd_en  = win0;
  assign vid.h_disp = H_DISP_C;
  assign vid.v_disp = V_DISP_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.video_hs    <= 1'b0;
      vid.video_vs    <= 1'b0;
      vid.video_de    <= 1'b0;
      vid.pixel_xpos  <= '0;
      vid.pixel_ypos  <= '0;
      vid.frame_start <= 1'b0;
      win_q           <= 1'b0;
    end else begin
      vid.video_hs    <= hs0;
      vid.video_vs    <= vs0;
      vid.video_de    <= de0;
      vid.pixel_xpos  <= de0 ? hr : '0;
      vid.pixel_ypos  <= de0 ? vr : '0;
      vid.frame_start <= (h_cnt == '0) && (v_cnt == '0);
      win_q           <= win0;
    end
  end

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = IMG_W / 8;
  logic [2:0] bar0, bar_q;

  always_comb begin
    bar0 = '0;
    for (int i = 1; i < 8; i++)
      if (xr >= CW'(i * BAR_W)) bar0 = 3'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bar_q <= '0;
    else        bar_q <= bar0;
  end
`endif

  // rd_data arrives one clk after rd_en, i.e. in the same cycle as the registered window.
  always_comb begin
    vid.video_rgb = '0;
    if (win_q)
      vid.video_rgb = {vid.rd_data[15:11], vid.rd_data[15:13],
                       vid.rd_data[10:5],  vid.rd_data[10:9],
                       vid.rd_data[4:0],   vid.rd_data[4:2]};
`ifdef TEST_PATTERN_EN
    // Bar colour bits: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
    if (win_q && vid.pattern_en)
      vid.video_rgb = {{8{~bar_q[1]}}, {8{~bar_q[2]}}, {8{~bar_q[0]}}};
`endif
  end
endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench for hdmi_video_timing on a shrunk raster (46 clk x 23 lines).
module tb_hdmi_video_timing;
  localparam int HT = 46;
  localparam int VT = 23;
  localparam int FT = HT * VT;

  logic clk, rst_n;
  int   passed, total;

  hdmi_video_timing_if vif_a ();
  hdmi_video_timing_if vif_b ();

  hdmi_video_timing #(
    .H_SYNC(4), .H_BACK(6), .H_DISP(32), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(3), .V_DISP(16), .V_FRONT(2),
    .IMG_W(16), .IMG_H(8)
  ) u_dut_a (.clk(clk), .rst_n(rst_n), .vid(vif_a));

  hdmi_video_timing #(
    .H_SYNC(4), .H_BACK(6), .H_DISP(32), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(3), .V_DISP(16), .V_FRONT(2),
    .IMG_W(32), .IMG_H(16)
  ) u_dut_b (.clk(clk), .rst_n(rst_n), .vid(vif_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  logic [15:0] rd_tab  [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410};
  logic [23:0] rgb_tab [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h848284};

  initial begin
    int hs_hi, vs_hi, de_hi, rd_a, rd_b, fs_cnt;
    int hs_r0, hs_r1, vs_r0, vs_r1, first_rd, last_rd;
    int rgb_bad, pos_bad, deb_bad;
    int p, h, v, exp_rgb, exp_x, exp_y;
    logic prev_hs, prev_vs, prev_rdb, win, de;
    passed = 0; total = 0;
    hs_hi = 0; vs_hi = 0; de_hi = 0; rd_a = 0; rd_b = 0; fs_cnt = 0;
    hs_r0 = -1; hs_r1 = -1; vs_r0 = -1; vs_r1 = -1; first_rd = -1; last_rd = -1;
    rgb_bad = 0; pos_bad = 0; deb_bad = 0;
    prev_hs = 1'b0; prev_vs = 1'b0; prev_rdb = 1'b0;
    rst_n = 1'b0;
    vif_a.rd_data = '0; vif_b.rd_data = '0;
    vif_a.pattern_en = 1'b0; vif_b.pattern_en = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {vif_a.video_hs, vif_a.video_vs, vif_a.video_de,
                    vif_a.frame_start, vif_a.rd_en}, 0);
    chk("rst_rgb", vif_a.video_rgb, 0);
    chk("rst_pos", {vif_a.pixel_xpos, vif_a.pixel_ypos}, 0);
    chk("h_disp", vif_a.h_disp, 32);
    chk("v_disp", vif_a.v_disp, 16);

    @(negedge clk) rst_n = 1'b1;

    // Two full frames; at step i the counters hold linear position i mod FT
    // and the video outputs describe position i-1.
    for (int i = 1; i <= 2 * FT; i++) begin
      @(posedge clk);
      #1;
      p = (i - 1) % FT;
      h = p % HT;
      v = p / HT;
      vif_a.rd_data = rd_tab[p % 4];
      vif_b.rd_data = rd_tab[p % 4];
      #1;
      if (i == 1) begin
        chk("fs_first_edge", vif_a.frame_start, 1);
        chk("vs_first_edge", vif_a.video_vs, 1);
        chk("hs_first_edge", vif_a.video_hs, 1);
      end
      if (i == 2) chk("fs_one_clk", vif_a.frame_start, 0);
      if (i == 432) begin
        chk("pre_win_rgb", vif_a.video_rgb, 0);
        chk("pre_win_x", vif_a.pixel_xpos, 7);
      end
      if (i == 433) begin
        chk("win_rgb_red", vif_a.video_rgb, 24'hFF0000);
        chk("win_de", vif_a.video_de, 1);
        chk("win_xy", {vif_a.pixel_xpos, vif_a.pixel_ypos}, {11'd8, 11'd4});
      end

      win = (h >= 18) && (h < 34) && (v >= 9) && (v < 17);
      de  = (h >= 10) && (h < 42) && (v >= 5) && (v < 21);
      exp_rgb = win ? int'(rgb_tab[p % 4]) : 0;
      exp_x   = de ? h - 10 : 0;
      exp_y   = de ? v - 5 : 0;
      if (vif_a.video_rgb != exp_rgb) rgb_bad++;
      if (vif_a.video_de != de || vif_a.pixel_xpos != exp_x || vif_a.pixel_ypos != exp_y)
        pos_bad++;
      if (vif_b.video_de != prev_rdb) deb_bad++;
      prev_rdb = vif_b.rd_en;

      hs_hi  += vif_a.video_hs;
      vs_hi  += vif_a.video_vs;
      de_hi  += vif_a.video_de;
      fs_cnt += vif_a.frame_start;
      rd_b   += vif_b.rd_en;
      if (vif_a.rd_en) begin
        rd_a++;
        if (first_rd < 0) first_rd = i % FT;
        if (i < FT) last_rd = i % FT;
      end
      if (vif_a.video_hs && !prev_hs) begin
        if (hs_r0 < 0) hs_r0 = i; else if (hs_r1 < 0) hs_r1 = i;
      end
      if (vif_a.video_vs && !prev_vs) begin
        if (vs_r0 < 0) vs_r0 = i; else if (vs_r1 < 0) vs_r1 = i;
      end
      prev_hs = vif_a.video_hs;
      prev_vs = vif_a.video_vs;
    end

    chk("hs_period", hs_r1 - hs_r0, 46);
    chk("vs_period", vs_r1 - vs_r0, 1058);
    chk("hs_high", hs_hi, 184);
    chk("vs_high", vs_hi, 184);
    chk("de_high", de_hi, 1024);
    chk("fs_count", fs_cnt, 2);
    chk("rd_count_a", rd_a, 256);
    chk("first_rd_pos", first_rd, 432);
    chk("last_rd_pos", last_rd, 769);
    chk("rgb_errors", rgb_bad, 0);
    chk("pos_errors", pos_bad, 0);
    chk("full_rd_vs_de", deb_bad, 0);
    chk("rd_count_b", rd_b, 1024);

    // Mid-frame reset inside the window (line 12, clk 20).
    repeat (572) @(posedge clk);
    #1;
    chk("mid_rd_en", vif_a.rd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ctl", {vif_a.video_hs, vif_a.video_vs, vif_a.video_de,
                      vif_a.frame_start, vif_a.rd_en}, 0);
    chk("async_rgb", vif_a.video_rgb, 0);
    chk("async_pos", {vif_a.pixel_xpos, vif_a.pixel_ypos}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    vif_a.rd_data = '0;
    @(posedge clk); #1;
    chk("re_fs_pulse", vif_a.frame_start, 1);
    @(posedge clk); #1;
    chk("re_fs_drop", vif_a.frame_start, 0);
    chk("re_hs", vif_a.video_hs, 1);

`ifdef TEST_PATTERN_EN
    vif_a.pattern_en = 1'b1;
    repeat (431) @(posedge clk);
    #1;
    chk("bar_white", vif_a.video_rgb, 24'hFFFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("bar_yellow", vif_a.video_rgb, 24'hFFFF00);
    repeat (12) @(posedge clk);
    #1;
    chk("bar_black", vif_a.video_rgb, 24'h000000);
    chk("bar_rd_en", vif_a.rd_en, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
